// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    BYTES,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
module word_assembler
  import inst_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word_out <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word_out <= {word_out[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // High while three bytes are held: the next shift completes the word.
  assign word_full = (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the CPU in reset meanwhile.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

  state_t                  state;
  logic [7:0]              len_hi;
  logic [LEN_WIDTH-1:0]    count;
  logic [LEN_WIDTH-1:0]    hdr;
  logic [LEN_WIDTH-1:0]    idx_next;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    xfer;
  logic                    word_full;

  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == BYTES);
  assign xfer       = byte_valid && byte_ready;
  assign hdr        = LEN_WIDTH'({len_hi, byte_data});
  assign idx_next   = LEN_WIDTH'(word_idx) + LEN_WIDTH'(1);

  // The shift register is the write-data flop: it holds the full word during WRITE.
  word_assembler u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == LEN_LO),
    .shift_en (xfer && (state == BYTES)),
    .byte_in  (byte_data),
    .word_out (imem_wdata),
    .word_full(word_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      len_hi    <= '0;
      count     <= '0;
      word_idx  <= '0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (load_start) begin
            state     <= LEN_HI;
            cpu_reset <= 1'b1;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            count    <= hdr;
            word_idx <= '0;
            if (hdr == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              busy      <= 1'b0;
            end else if ({1'b0, hdr} > DEPTH) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= BYTES;
            end
          end
        end
        BYTES: begin
          if (xfer && word_full) begin
            state     <= WRITE;
            imem_we   <= 1'b1;
            imem_addr <= word_idx;
          end
        end
        WRITE: begin
          word_idx <= word_idx + ADDR_WIDTH'(1);
          if (idx_next == count) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
          end else begin
            state <= BYTES;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader.
module tb_inst_mem_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  inst_mem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .load_start(load_start),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned wr_times[$];
  logic [31:0] img[$];
  bit          prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected-write and expected-done queues as the DUT presents them.
  always @(negedge clock) begin
    wr_t e;
    cyc++;
    if (!reset) begin
      if (imem_we) begin
        wr_times.push_back(cyc);
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL we_back_to_back: imem_we high in consecutive cycles at cycle %0d", cyc);
        end else if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", imem_addr, imem_wdata);
        end else begin
          e = exp_wr.pop_front();
          if (imem_addr !== e.addr || imem_wdata !== e.data) begin
            errors++;
            $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                     imem_addr, imem_wdata, e.addr, e.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          exp_done--;
          if (cpu_reset !== 1'b0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL done_state: cpu_reset %0b pending writes %0d expected 0 and 0",
                     cpu_reset, exp_wr.size());
          end
        end
      end
    end
    prev_we = imem_we;
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int unsigned n = 0;
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) begin
        byte_valid = 1'b0;
        @(negedge clock);
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready) begin
      @(negedge clock);
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL byte_timeout: byte_ready 0 for %0d cycles expected 1", n);
        byte_valid = 1'b0;
        return;
      end
    end
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_done != 0 || exp_wr.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("load_complete", 64'(exp_done + exp_wr.size()), 64'd0);
    exp_done = 0;
    exp_wr.delete();
  endtask

  // Model: a legal image of cnt words produces writes img[i] at address i, then one done.
  task automatic run_load(input int unsigned cnt, input bit gappy, input int mid_at);
    pulse_start();
    check("start", {busy, cpu_reset, error}, 3'b110);
    if (cnt <= DEPTH) begin
      for (int unsigned i = 0; i < cnt; i++) exp_wr.push_back('{addr: AW'(i), data: img[i]});
      exp_done++;
    end
    send_byte(8'(cnt >> 8), gappy);
    send_byte(8'(cnt), gappy);
    if (cnt > DEPTH) begin
      check("err_state", {error, cpu_reset, byte_ready, busy, imem_we}, 5'b11000);
      return;
    end
    if (cnt == 0) check("zero_done", {done, cpu_reset, imem_we}, 3'b100);
    for (int unsigned i = 0; i < cnt; i++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mid_at >= 0 && int'(i * 4 + b) == mid_at) load_start = 1'b1;
        send_byte(8'(img[i] >> (24 - 8 * b)), gappy);
        load_start = 1'b0;
      end
    end
    wait_idle(cnt * 20 + 50);
  endtask

  task automatic fill_img(input int unsigned n);
    img.delete();
    for (int unsigned i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_ctrl", {byte_ready, imem_we, cpu_reset, busy, done, error}, 6'b001000);
    check("reset_addr_data", {imem_addr, imem_wdata}, '0);
    reset = 1'b0;
    @(negedge clock);

    // Directed two-word image with back-to-back bytes.
    img.delete();
    img.push_back(32'h2408_0005);
    img.push_back(32'hAC08_0000);
    wr_times.delete();
    run_load(2, 1'b0, -1);
    check("write_count", 64'(wr_times.size()), 64'd2);
    if (wr_times.size() == 2) check("write_spacing", 64'(wr_times[1] - wr_times[0]), 64'd5);
    repeat (3) @(negedge clock);
    check("idle_after_load", {cpu_reset, busy, byte_ready}, 3'b000);

    // Empty image.
    img.delete();
    run_load(0, 1'b0, -1);

    // Oversized header, then recovery from ERR.
    run_load(DEPTH + 1, 1'b0, -1);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clock);
    check("err_holds", {error, cpu_reset, byte_ready}, 3'b110);
    byte_valid = 1'b0;
    fill_img(1);
    run_load(1, 1'b0, -1);

    // Random valid gaps across three words.
    fill_img(3);
    run_load(3, 1'b1, -1);

    // Reset after the first of three words.
    fill_img(3);
    pulse_start();
    exp_wr.push_back('{addr: '0, data: img[0]});
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int unsigned b = 0; b < 4; b++) send_byte(8'(img[0] >> (24 - 8 * b)), 1'b0);
    send_byte(8'(img[1] >> 24), 1'b0);
    send_byte(8'(img[1] >> 16), 1'b0);
    check("first_word_written", 64'(exp_wr.size()), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset_mid", {cpu_reset, busy, imem_we, byte_ready, done}, 5'b10000);
    exp_wr.delete();
    fill_img(2);
    run_load(2, 1'b0, -1);

    // load_start mid-stream is ignored; after done it restarts and reasserts cpu_reset.
    fill_img(3);
    run_load(3, 1'b0, 5);
    img.delete();
    run_load(0, 1'b0, -1);

    // Full-depth image: last address DEPTH-1.
    fill_img(DEPTH);
    run_load(DEPTH, 1'b0, -1);

    for (int unsigned k = 0; k < 4; k++) begin
      int unsigned n;
      n = $urandom_range(6, 1);
      fill_img(n);
      run_load(n, 1'($urandom_range(1, 0)), -1);
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
